// File: rtl/cla16_bus_master_if.sv
// Byte-wide register bus between the CLA16 host master and the CLA wrapper.
// The master drives DIN/ADDR/RDWR; the wrapper returns DOUT one cycle after ADDR.
interface cla16_bus_master_if;
    logic [7:0] BUS_DIN;
    logic [7:0] BUS_ADDR;
    logic       BUS_RDWR;  // 1 = write, 0 = read
    logic [7:0] BUS_DOUT;

    modport master (
        output BUS_DIN,
        output BUS_ADDR,
        output BUS_RDWR,
        input  BUS_DOUT
    );

    modport slave (
        input  BUS_DIN,
        input  BUS_ADDR,
        input  BUS_RDWR,
        output BUS_DOUT
    );
endinterface

// File: rtl/cla16_bus_master.sv
// Host-side initiator for the 16-bit CLA wrapper register bus.
// Writes A, B, CIN as five bytes, waits SETTLE_CYCLES, reads back four result
// bytes and presents SUM/COUT/P/G with a one-cycle DONE pulse.
// Optional readback self-check: define CLA16_MASTER_CHECK_EN.
module cla16_bus_master #(
    parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    input  logic [15:0]               A,
    input  logic [15:0]               B,
    input  logic                      CIN,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [15:0]               SUM,
    output logic                      COUT,
    output logic [3:0]                P,
    output logic [3:0]                G,
    output logic                      MISMATCH,
    cla16_bus_master_if.master        bus
);

    typedef enum logic [2:0] {StIdle, StWrite, StSettle, StRead, StDrain, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic        cin_q, cin_d;
    logic [7:0]  din_d, addr_d;
    logic        rdwr_d;
    logic [7:0]  pg_q, sum_lo_q, sum_hi_q;

    // Next state, operand latch and next bus values (bus outputs are registered from these)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        din_d   = 8'h00;
        addr_d  = 8'hFF;
        rdwr_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = StWrite;
                    cnt_d   = 4'd0;
                    a_d     = A;
                    b_d     = B;
                    cin_d   = CIN;
                end
            end
            StWrite: begin
                if (cnt_q == 4'd4) begin
                    state_d = StSettle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSettle: begin
                if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
                    state_d = StRead;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StRead: begin
                if (cnt_q == 4'd3) begin
                    state_d = StDrain;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        case (state_d)
            StWrite: begin
                rdwr_d = 1'b1;
                addr_d = {5'd0, cnt_d[2:0]};
                case (cnt_d[2:0])
                    3'd0:    din_d = a_d[7:0];
                    3'd1:    din_d = a_d[15:8];
                    3'd2:    din_d = b_d[7:0];
                    3'd3:    din_d = b_d[15:8];
                    default: din_d = {7'd0, cin_d};
                endcase
            end
            StRead:  addr_d = {5'd0, cnt_d[2:0]};
            default: ;
        endcase
    end

    // Control state, latched operands and registered bus/status outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            a_q          <= 16'd0;
            b_q          <= 16'd0;
            cin_q        <= 1'b0;
            bus.BUS_DIN  <= 8'h00;
            bus.BUS_ADDR <= 8'hFF;
            bus.BUS_RDWR <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            bus.BUS_DIN  <= din_d;
            bus.BUS_ADDR <= addr_d;
            bus.BUS_RDWR <= rdwr_d;
            BUSY         <= (state_d != StIdle);
            DONE         <= (state_d == StDone);
        end
    end

    // Readback capture: byte for read address k arrives while cnt_q == k+1; DRAIN takes byte 3
    always_ff @(posedge CLK) begin
        if (RST) begin
            pg_q     <= 8'h00;
            sum_lo_q <= 8'h00;
            sum_hi_q <= 8'h00;
            SUM      <= 16'd0;
            COUT     <= 1'b0;
            P        <= 4'd0;
            G        <= 4'd0;
        end else begin
            if (state_q == StRead) begin
                case (cnt_q)
                    4'd1:    pg_q     <= bus.BUS_DOUT;
                    4'd2:    sum_lo_q <= bus.BUS_DOUT;
                    4'd3:    sum_hi_q <= bus.BUS_DOUT;
                    default: ;
                endcase
            end
            if (state_q == StDrain) begin
                SUM  <= {sum_hi_q, sum_lo_q};
                COUT <= bus.BUS_DOUT[0];
                P    <= pg_q[7:4];
                G    <= pg_q[3:0];
            end
        end
    end

`ifdef CLA16_MASTER_CHECK_EN
    logic [16:0] ref_sum;
    assign ref_sum = {1'b0, a_q} + {1'b0, b_q} + {16'd0, cin_q};

    // Compare local reference against the bytes being committed at the end of DRAIN
    always_ff @(posedge CLK) begin
        if (RST) begin
            MISMATCH <= 1'b0;
        end else if (state_q == StDrain) begin
            MISMATCH <= (ref_sum != {bus.BUS_DOUT[0], sum_hi_q, sum_lo_q}) ||
                        (bus.BUS_DOUT[7:1] != 7'd0);
        end
    end
`else
    logic unused_dout_hi;
    assign unused_dout_hi = ^bus.BUS_DOUT[7:1];
    assign MISMATCH       = 1'b0;
`endif

endmodule

// File: tb/tb_cla16_bus_master.sv
// Directed bench for cla16_bus_master with a behavioural CLA wrapper on the bus.
module tb_cla16_bus_master;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [15:0] A = 16'd0;
    logic [15:0] B = 16'd0;
    logic        CIN = 1'b0;
    logic        BUSY, DONE, COUT, MISMATCH;
    logic [15:0] SUM;
    logic [3:0]  P, G;

    int checks = 0;
    int errors = 0;
    logic corrupt = 1'b0;

    cla16_bus_master_if bus_if ();

    cla16_bus_master #(.SETTLE_CYCLES(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .A        (A),
        .B        (B),
        .CIN      (CIN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .SUM      (SUM),
        .COUT     (COUT),
        .P        (P),
        .G        (G),
        .MISMATCH (MISMATCH),
        .bus      (bus_if)
    );

    always #5 CLK = ~CLK;

    // Wrapper model: operand bytes, registered 4-bit-group CLA result, registered DOUT
    logic [7:0]  ops [5];
    logic [16:0] res_sum;
    logic [7:0]  res_pg;

    function automatic logic [7:0] pg_of(input logic [15:0] a, input logic [15:0] b);
        logic [3:0] pp, gg, gp, gr;
        for (int k = 0; k < 4; k++) begin
            pp = a[4*k +: 4] ^ b[4*k +: 4];
            gg = a[4*k +: 4] & b[4*k +: 4];
            gp[k] = &pp;
            gr[k] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) |
                    (pp[3] & pp[2] & pp[1] & gg[0]);
        end
        return {gp, gr};
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < 5; k++) ops[k] <= 8'h00;
            res_sum         <= 17'd0;
            res_pg          <= 8'h00;
            bus_if.BUS_DOUT <= 8'h00;
        end else begin
            if (bus_if.BUS_RDWR) begin
                if (bus_if.BUS_ADDR <= 8'd4) ops[bus_if.BUS_ADDR[2:0]] <= bus_if.BUS_DIN;
                else for (int k = 0; k < 5; k++) ops[k] <= 8'h00;
            end
            res_sum <= {1'b0, ops[1], ops[0]} + {1'b0, ops[3], ops[2]} + {16'd0, ops[4][0]};
            res_pg  <= pg_of({ops[1], ops[0]}, {ops[3], ops[2]});
            case (bus_if.BUS_ADDR)
                8'd0:    bus_if.BUS_DOUT <= res_pg;
                8'd1:    bus_if.BUS_DOUT <= res_sum[7:0] ^ {7'd0, corrupt};
                8'd2:    bus_if.BUS_DOUT <= res_sum[15:8];
                8'd3:    bus_if.BUS_DOUT <= {7'd0, res_sum[16]};
                default: bus_if.BUS_DOUT <= 8'h00;
            endcase
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request; returns the cycle (START cycle = 0) DONE was seen, or -1
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          output int done_cyc);
        A = a; B = b; CIN = c; START = 1'b1;
        tick();
        START = 1'b0;
        done_cyc = -1;
        for (int n = 1; n <= 40; n++) begin
            if (DONE === 1'b1) begin
                done_cyc = n;
                break;
            end
            tick();
        end
    endtask

    initial begin
        logic [7:0] wd [5];
        int dc;
        int ndone;
        logic exp_mm;
`ifdef CLA16_MASTER_CHECK_EN
        exp_mm = 1'b1;
`else
        exp_mm = 1'b0;
`endif
        wd = '{8'h34, 8'h12, 8'h21, 8'h43, 8'h00};

        // Reset state
        tick(); tick(); tick();
        RST = 1'b0;
        tick();
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_mismatch", {31'd0, MISMATCH}, 32'd0);
        check("rst_sum", {16'd0, SUM}, 32'd0);
        check("rst_cout_p_g", {23'd0, COUT, P, G}, 32'd0);
        check("rst_addr", {24'd0, bus_if.BUS_ADDR}, 32'hFF);
        check("rst_rdwr_din", {23'd0, bus_if.BUS_RDWR, bus_if.BUS_DIN}, 32'd0);

        // Test 1: 1234 + 4321 with full bus trace
        A = 16'h1234; B = 16'h4321; CIN = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t1_wr%0d", i),
                  {15'd0, bus_if.BUS_RDWR, bus_if.BUS_ADDR, bus_if.BUS_DIN},
                  {15'd0, 1'b1, 8'(i), wd[i]});
            check($sformatf("t1_busy_w%0d", i), {31'd0, BUSY}, 32'd1);
            tick();
        end
        check("t1_settle6", {15'd0, bus_if.BUS_RDWR, bus_if.BUS_ADDR, bus_if.BUS_DIN},
              {15'd0, 1'b0, 8'hFF, 8'h00});
        tick();
        check("t1_settle7_addr", {24'd0, bus_if.BUS_ADDR}, 32'hFF);
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_rd%0d", i), {23'd0, bus_if.BUS_RDWR, bus_if.BUS_ADDR},
                  {23'd0, 1'b0, 8'(i)});
            tick();
        end
        check("t1_drain_addr", {24'd0, bus_if.BUS_ADDR}, 32'hFF);
        check("t1_drain_nodone", {31'd0, DONE}, 32'd0);
        tick();
        check("t1_done13", {31'd0, DONE}, 32'd1);
        check("t1_busy13", {31'd0, BUSY}, 32'd1);
        check("t1_sum", {16'd0, SUM}, 32'h5555);
        check("t1_cout_p_g", {23'd0, COUT, P, G}, 32'd0);
        check("t1_mismatch", {31'd0, MISMATCH}, 32'd0);
        tick();
        check("t1_done_pulse", {30'd0, DONE, BUSY}, 32'd0);
        check("t1_sum_hold", {16'd0, SUM}, 32'h5555);

        // Test 2: FFFF + 0000 + 1, full carry ripple
        run_op(16'hFFFF, 16'h0000, 1'b1, dc);
        check("t2_done_cyc", dc, 32'd13);
        check("t2_sum", {16'd0, SUM}, 32'h0000);
        check("t2_cout", {31'd0, COUT}, 32'd1);
        check("t2_p", {28'd0, P}, 32'hF);
        check("t2_g", {28'd0, G}, 32'h0);
        check("t2_mismatch", {31'd0, MISMATCH}, 32'd0);
        tick();

        // Test 3: zeros, then back-to-back START in the cycle after DONE
        run_op(16'h0000, 16'h0000, 1'b0, dc);
        check("t3a_done_cyc", dc, 32'd13);
        check("t3a_all", {11'd0, COUT, P, G, SUM}, 32'd0);
        tick();
        check("t3_idle_after_done", {31'd0, BUSY}, 32'd0);
        run_op(16'h00FF, 16'h0001, 1'b0, dc);
        check("t3b_done_cyc", dc, 32'd13);
        check("t3b_sum", {16'd0, SUM}, 32'h0100);
        check("t3b_cout", {31'd0, COUT}, 32'd0);
        check("t3b_pg", {24'd0, P, G}, 32'h21);
        tick();

        // Test 4: second START in cycle 4 with new operands is ignored
        A = 16'h1111; B = 16'h2222; CIN = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        tick(); tick(); tick();
        A = 16'h5555; B = 16'h5555; CIN = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        ndone = 0;
        dc = -1;
        for (int n = 5; n <= 40; n++) begin
            if (DONE === 1'b1) begin
                ndone++;
                if (dc < 0) dc = n;
            end
            tick();
        end
        check("t4_ndone", ndone, 32'd1);
        check("t4_done_cyc", dc, 32'd13);
        check("t4_sum", {16'd0, SUM}, 32'h3333);
        check("t4_cout", {31'd0, COUT}, 32'd0);

        // Test 5: RST in cycle 7 aborts, then a fresh request completes
        A = 16'hAAAA; B = 16'h5555; CIN = 1'b1; START = 1'b1;
        tick();
        START = 1'b0;
        for (int n = 1; n < 7; n++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t5_busy", {31'd0, BUSY}, 32'd0);
        check("t5_done", {31'd0, DONE}, 32'd0);
        check("t5_sum", {16'd0, SUM}, 32'd0);
        check("t5_addr", {24'd0, bus_if.BUS_ADDR}, 32'hFF);
        check("t5_rdwr", {31'd0, bus_if.BUS_RDWR}, 32'd0);
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            if (DONE === 1'b1) ndone++;
            tick();
        end
        check("t5_no_done", ndone, 32'd0);
        run_op(16'h0ABC, 16'h0123, 1'b1, dc);
        check("t5_done_cyc", dc, 32'd13);
        check("t5_sum_after", {16'd0, SUM}, 32'h0BE0);
        check("t5_cout_after", {31'd0, COUT}, 32'd0);
        tick();

        // Test 6: corrupted SUM low byte on readback
        corrupt = 1'b1;
        run_op(16'h0001, 16'h0001, 1'b0, dc);
        corrupt = 1'b0;
        check("t6_done_cyc", dc, 32'd13);
        check("t6_sum", {16'd0, SUM}, 32'h0003);
        check("t6_mismatch", {31'd0, MISMATCH}, {31'd0, exp_mm});
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
